// File: rtl/rv32_control_pkg.sv
// Shared encodings for the RV32I multicycle control path.
// Contents:
//   state_e        sequencer states
//   iclass_e       instruction classes produced by instr_class_decode
//   OPC_*          base opcodes, INSN_EBREAK full encoding
//   ALU_*          ALU operation codes driven on alu_op_o
//   ADDR_*, PC_SRC_*, ALU_A_*, ALU_B_*, WD_*   datapath mux selects
//   alu_op_decode  funct3/funct7 -> ALU operation for OP and OP-IMM
package rv32_control_pkg;

   typedef enum logic [2:0] {
      S_RESET   = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      CL_NONE   = 4'd0,
      CL_LUI    = 4'd1,
      CL_AUIPC  = 4'd2,
      CL_JAL    = 4'd3,
      CL_JALR   = 4'd4,
      CL_BRANCH = 4'd5,
      CL_LOAD   = 4'd6,
      CL_STORE  = 4'd7,
      CL_OPIMM  = 4'd8,
      CL_OP     = 4'd9,
      CL_SYSTEM = 4'd10
   } iclass_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_ALU    = 1'b1;
   localparam logic       PC_SRC_PC4  = 1'b0;
   localparam logic       PC_SRC_ALU  = 1'b1;
   localparam logic [1:0] ALU_A_RS1   = 2'd0;
   localparam logic [1:0] ALU_A_PC    = 2'd1;
   localparam logic [1:0] ALU_A_ZERO  = 2'd2;
   localparam logic [1:0] ALU_B_RS2   = 2'd0;
   localparam logic [1:0] ALU_B_IMM   = 2'd1;
   localparam logic [1:0] ALU_B_4     = 2'd2;
   localparam logic [1:0] WD_ALU      = 2'd0;
   localparam logic [1:0] WD_MEM      = 2'd1;
   localparam logic [1:0] WD_PC4      = 2'd2;

   // alt is instruction bit 30. It selects SUB only for register-register
   // ops (ADDI has no subtract form, bit 30 there is immediate data), but
   // selects SRA for both SRL/SRLI forms.
   function automatic logic [3:0] alu_op_decode(input logic [2:0] funct3,
                                                input logic       alt,
                                                input logic       is_reg);
      logic [3:0] op;
      case (funct3)
         3'd0:    op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier for the multicycle sequencer.
// Ports:
//   ir_i       in   32  instruction word
//   class_o    out  4   instruction class (iclass_e)
//   illegal_o  out  1   unsupported opcode or reserved funct3
//   ebreak_o   out  1   exact EBREAK encoding
module instr_class_decode
   import rv32_control_pkg::*;
(
   input  logic [31:0] ir_i,
   output iclass_e     class_o,
   output logic        illegal_o,
   output logic        ebreak_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = ir_i[6:0];
   assign funct3 = ir_i[14:12];

   always_comb begin
      class_o   = CL_NONE;
      illegal_o = 1'b0;
      ebreak_o  = 1'b0;
      case (opcode)
         OPC_LUI:   class_o = CL_LUI;
         OPC_AUIPC: class_o = CL_AUIPC;
         OPC_JAL:   class_o = CL_JAL;
         OPC_JALR:  class_o = CL_JALR;
         OPC_OPIMM: class_o = CL_OPIMM;
         OPC_OP:    class_o = CL_OP;
         OPC_BRANCH: begin
            class_o   = CL_BRANCH;
            illegal_o = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         OPC_LOAD: begin
            class_o   = CL_LOAD;
            illegal_o = (funct3 == 3'd3) || (funct3 >= 3'd6);
         end
         OPC_STORE: begin
            class_o   = CL_STORE;
            illegal_o = (funct3 >= 3'd3);
         end
         OPC_SYSTEM: begin
            // Only EBREAK is supported; every other SYSTEM encoding halts as illegal.
            class_o   = CL_SYSTEM;
            ebreak_o  = (ir_i == INSN_EBREAK);
            illegal_o = (ir_i != INSN_EBREAK);
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM of the RV32I multicycle core. Steps each instruction through
// fetch/decode/execute/memory/write-back and drives the datapath selects.
// Ports:
//   clk_i, reset_i (sync, active high)
//   ir_i            instruction register (valid from DECODE on)
//   mem_ready_i     memory completes the current access this cycle
//   branch_taken_i  comparator result, sampled in EXECUTE
//   halt_i          halt request, honoured in FETCH
//   pc_ld_o, pc_src_o, ir_ld_o, mem_rd_o, mem_wr_o, addr_src_o
//   alu_a_src_o, alu_b_src_o, alu_op_o, wd_src_o, rf_wr_o
//   retire_o        pulse on the cycle an instruction completes
//   halted_o        high in S_HALT
//   illegal_o       sticky, set when the halt came from an illegal encoding
//   retired_cnt_o   retired-instruction count, wraps
//
// state     | meaning
// S_RESET   | post-reset idle cycle, all outputs low
// S_FETCH   | read instruction at PC, wait for mem_ready_i
// S_DECODE  | classify IR, trap illegal/EBREAK
// S_EXECUTE | ALU work; branches and jumps complete here
// S_MEM     | load/store data access at ALU result address
// S_WB      | register-file write, completes ALU/LUI/AUIPC/load
// S_HALT    | stopped until reset
module multicycle_sequencer
   import rv32_control_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [31:0]          ir_i,
   input  logic                 mem_ready_i,
   input  logic                 branch_taken_i,
   input  logic                 halt_i,
   output logic                 pc_ld_o,
   output logic                 pc_src_o,
   output logic                 ir_ld_o,
   output logic                 mem_rd_o,
   output logic                 mem_wr_o,
   output logic                 addr_src_o,
   output logic [1:0]           alu_a_src_o,
   output logic [1:0]           alu_b_src_o,
   output logic [3:0]           alu_op_o,
   output logic [1:0]           wd_src_o,
   output logic                 rf_wr_o,
   output logic                 retire_o,
   output logic                 halted_o,
   output logic                 illegal_o,
   output logic [CNT_WIDTH-1:0] retired_cnt_o
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 illegal_q;
   logic                 illegal_set;

   iclass_e              cls;
   logic                 dec_illegal;
   logic                 dec_ebreak;
   logic                 is_load;

   instr_class_decode u_decode (
      .ir_i      (ir_i),
      .class_o   (cls),
      .illegal_o (dec_illegal),
      .ebreak_o  (dec_ebreak)
   );

   assign is_load = (cls == CL_LOAD);

   always_comb begin
      state_d     = state_q;
      illegal_set = 1'b0;
      pc_ld_o     = 1'b0;
      pc_src_o    = PC_SRC_PC4;
      ir_ld_o     = 1'b0;
      mem_rd_o    = 1'b0;
      mem_wr_o    = 1'b0;
      addr_src_o  = ADDR_PC;
      alu_a_src_o = ALU_A_RS1;
      alu_b_src_o = ALU_B_RS2;
      alu_op_o    = ALU_ADD;
      wd_src_o    = WD_ALU;
      rf_wr_o     = 1'b0;
      retire_o    = 1'b0;
      halted_o    = 1'b0;

      case (state_q)
         S_RESET: state_d = S_FETCH;

         S_FETCH: begin
            if (halt_i) begin
               state_d = S_HALT;
            end else begin
               mem_rd_o   = 1'b1;
               addr_src_o = ADDR_PC;
               if (mem_ready_i) begin
                  ir_ld_o  = 1'b1;
                  pc_ld_o  = 1'b1;
                  pc_src_o = PC_SRC_PC4;
                  state_d  = S_DECODE;
               end
            end
         end

         S_DECODE: begin
            if (dec_illegal) begin
               illegal_set = 1'b1;
               state_d     = S_HALT;
            end else if (dec_ebreak) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXECUTE;
            end
         end

         S_EXECUTE: begin
            alu_b_src_o = ALU_B_IMM;
            case (cls)
               CL_BRANCH: begin
                  alu_a_src_o = ALU_A_PC;
                  pc_ld_o     = branch_taken_i;
                  pc_src_o    = PC_SRC_ALU;
                  retire_o    = 1'b1;
                  state_d     = S_FETCH;
               end
               CL_JAL, CL_JALR: begin
                  alu_a_src_o = (cls == CL_JAL) ? ALU_A_PC : ALU_A_RS1;
                  rf_wr_o     = 1'b1;
                  wd_src_o    = WD_PC4;
                  pc_ld_o     = 1'b1;
                  pc_src_o    = PC_SRC_ALU;
                  retire_o    = 1'b1;
                  state_d     = S_FETCH;
               end
               CL_LOAD, CL_STORE: state_d = S_MEM;
               CL_OP: begin
                  alu_b_src_o = ALU_B_RS2;
                  alu_op_o    = alu_op_decode(ir_i[14:12], ir_i[30], 1'b1);
                  state_d     = S_WB;
               end
               CL_OPIMM: begin
                  alu_op_o = alu_op_decode(ir_i[14:12], ir_i[30], 1'b0);
                  state_d  = S_WB;
               end
               CL_LUI: begin
                  alu_a_src_o = ALU_A_ZERO;
                  state_d     = S_WB;
               end
               CL_AUIPC: begin
                  alu_a_src_o = ALU_A_PC;
                  state_d     = S_WB;
               end
               // IR changed under us after DECODE; stop rather than guess.
               default: state_d = S_HALT;
            endcase
         end

         S_MEM: begin
            addr_src_o = ADDR_ALU;
            mem_rd_o   = is_load;
            mem_wr_o   = !is_load;
            if (mem_ready_i) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  retire_o = 1'b1;
                  state_d  = S_FETCH;
               end
            end
         end

         S_WB: begin
            rf_wr_o  = 1'b1;
            wd_src_o = is_load ? WD_MEM : WD_ALU;
            retire_o = 1'b1;
            state_d  = S_FETCH;
         end

         S_HALT: halted_o = 1'b1;

         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_RESET;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire_o) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
         if (illegal_set) begin
            illegal_q <= 1'b1;
         end
      end
   end

   assign illegal_o     = illegal_q;
   assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
   import rv32_control_pkg::*;

   localparam int CW = 4;

   localparam int K_OP    = 0;
   localparam int K_OPIMM = 1;
   localparam int K_LUI   = 2;
   localparam int K_AUIPC = 3;
   localparam int K_JAL   = 4;
   localparam int K_JALR  = 5;
   localparam int K_BR    = 6;
   localparam int K_LD    = 7;
   localparam int K_ST    = 8;
   localparam int K_BAD   = 9;
   localparam int K_EBRK  = 10;

   // ISA meaning of funct3 for OP/OP-IMM (alternate forms handled separately)
   localparam logic [3:0] OP_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                         ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

   typedef struct packed {
      logic       pc_ld;
      logic       pc_src;
      logic       ir_ld;
      logic       mem_rd;
      logic       mem_wr;
      logic       addr_src;
      logic [1:0] a;
      logic [1:0] b;
      logic [3:0] op;
      logic [1:0] wd;
      logic       rf_wr;
      logic       retire;
      logic       halted;
   } ctl_t;

   logic          clk = 1'b0;
   logic          reset_i, mem_ready_i, branch_taken_i, halt_i;
   logic [31:0]   ir_i;
   logic          pc_ld_o, pc_src_o, ir_ld_o, mem_rd_o, mem_wr_o, addr_src_o;
   logic [1:0]    alu_a_src_o, alu_b_src_o, wd_src_o;
   logic [3:0]    alu_op_o;
   logic          rf_wr_o, retire_o, halted_o, illegal_o;
   logic [CW-1:0] retired_cnt_o;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [CW-1:0] cnt_m    = '0;
   logic          illegal_m = 1'b0;
   bit            force_halt = 1'b0;

   always #5 clk = ~clk;

   multicycle_sequencer #(.CNT_WIDTH(CW)) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .ir_i           (ir_i),
      .mem_ready_i    (mem_ready_i),
      .branch_taken_i (branch_taken_i),
      .halt_i         (halt_i),
      .pc_ld_o        (pc_ld_o),
      .pc_src_o       (pc_src_o),
      .ir_ld_o        (ir_ld_o),
      .mem_rd_o       (mem_rd_o),
      .mem_wr_o       (mem_wr_o),
      .addr_src_o     (addr_src_o),
      .alu_a_src_o    (alu_a_src_o),
      .alu_b_src_o    (alu_b_src_o),
      .alu_op_o       (alu_op_o),
      .wd_src_o       (wd_src_o),
      .rf_wr_o        (rf_wr_o),
      .retire_o       (retire_o),
      .halted_o       (halted_o),
      .illegal_o      (illegal_o),
      .retired_cnt_o  (retired_cnt_o)
   );

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic logic hval();
      return force_halt ? 1'b1 : rbit();
   endfunction

   // mode 0: strobes plus the selects qualified by an active strobe
   // mode 1: as 0, plus ALU selects/op
   // mode 2: every output bit
   task automatic step(input string tag, input ctl_t e, input int mode);
      ctl_t m, o;
      m = '0;
      if (mode == 2) begin
         m = '1;
      end else begin
         m.pc_ld = 1'b1; m.ir_ld = 1'b1; m.mem_rd = 1'b1; m.mem_wr = 1'b1;
         m.rf_wr = 1'b1; m.retire = 1'b1; m.halted = 1'b1;
         if (e.pc_ld)              m.pc_src   = 1'b1;
         if (e.mem_rd || e.mem_wr) m.addr_src = 1'b1;
         if (e.rf_wr)              m.wd       = '1;
         if (mode == 1) begin
            m.a = '1; m.b = '1; m.op = '1;
         end
      end
      @(negedge clk);
      o = {pc_ld_o, pc_src_o, ir_ld_o, mem_rd_o, mem_wr_o, addr_src_o,
           alu_a_src_o, alu_b_src_o, alu_op_o, wd_src_o, rf_wr_o, retire_o, halted_o};
      n_assert++;
      assert ((o & m) === (e & m)) else begin
         n_fail++;
         $error("FAIL %s ctl observed=%h required=%h mask=%h", tag, o, e, m);
      end
      n_assert++;
      assert (retired_cnt_o === cnt_m) else begin
         n_fail++;
         $error("FAIL %s cnt observed=%0d required=%0d", tag, retired_cnt_o, cnt_m);
      end
      n_assert++;
      assert (illegal_o === illegal_m) else begin
         n_fail++;
         $error("FAIL %s illegal observed=%b required=%b", tag, illegal_o, illegal_m);
      end
      @(posedge clk);
      #1;
      if (e.retire) cnt_m = cnt_m + 1'b1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; mem_ready_i = 1'b1; branch_taken_i = 1'b1;
      halt_i = rbit(); ir_i = $urandom;
      @(posedge clk);
      #1;
      cnt_m = '0; illegal_m = 1'b0;
      step("reset_hold", '0, 2);
      reset_i = 1'b0;
      step("reset_state", '0, 2);
   endtask

   task automatic halt_cycles(input string tag);
      ctl_t e;
      for (int i = 0; i < 3; i++) begin
         halt_i = rbit(); mem_ready_i = rbit(); branch_taken_i = rbit(); ir_i = $urandom;
         e = '0; e.halted = 1'b1;
         step(tag, e, 0);
      end
   endtask

   task automatic do_halt_fetch();
      halt_i = 1'b1; mem_ready_i = 1'b1; ir_i = $urandom;
      step("halt_fetch", '0, 0);
      halt_cycles("halted");
   endtask

   task automatic run_instr(input string tag, input logic [31:0] ir, input int kind,
                            input logic [3:0] opx, input int wf, input int wm,
                            input bit taken, input bit rst_in_mem);
      ctl_t e;
      halt_i = 1'b0; branch_taken_i = rbit();
      for (int i = 0; i <= wf; i++) begin
         ir_i = $urandom;
         mem_ready_i = (i == wf);
         e = '0; e.mem_rd = 1'b1; e.addr_src = ADDR_PC;
         if (i == wf) begin
            e.ir_ld = 1'b1; e.pc_ld = 1'b1; e.pc_src = PC_SRC_PC4;
         end
         step({tag, "_fetch"}, e, 0);
      end
      ir_i = ir; halt_i = hval(); mem_ready_i = rbit(); branch_taken_i = rbit();
      step({tag, "_decode"}, '0, 0);
      if (kind == K_BAD || kind == K_EBRK) begin
         if (kind == K_BAD) illegal_m = 1'b1;
         halt_cycles({tag, "_halt"});
         return;
      end
      halt_i = hval(); mem_ready_i = rbit();
      branch_taken_i = (kind == K_BR) ? taken : rbit();
      e = '0; e.a = ALU_A_RS1; e.b = ALU_B_IMM; e.op = ALU_ADD;
      case (kind)
         K_OP:    begin e.b = ALU_B_RS2; e.op = opx; end
         K_OPIMM: e.op = opx;
         K_LUI:   e.a = ALU_A_ZERO;
         K_AUIPC: e.a = ALU_A_PC;
         K_JAL, K_JALR: begin
            if (kind == K_JAL) e.a = ALU_A_PC;
            e.rf_wr = 1'b1; e.wd = WD_PC4; e.pc_ld = 1'b1; e.pc_src = PC_SRC_ALU;
            e.retire = 1'b1;
         end
         K_BR: begin
            e.a = ALU_A_PC; e.pc_ld = taken; e.pc_src = PC_SRC_ALU; e.retire = 1'b1;
         end
         default: ;
      endcase
      step({tag, "_exec"}, e, 1);
      if (e.retire) return;
      if (kind == K_LD || kind == K_ST) begin
         if (rst_in_mem) begin
            reset_i = 1'b1; mem_ready_i = 1'b0;
            e = '0; e.addr_src = ADDR_ALU; e.mem_wr = (kind == K_ST); e.mem_rd = (kind == K_LD);
            step({tag, "_mem_rst"}, e, 0);
            reset_i = 1'b0; cnt_m = '0; illegal_m = 1'b0;
            step({tag, "_after_rst"}, '0, 2);
            return;
         end
         for (int i = 0; i <= wm; i++) begin
            mem_ready_i = (i == wm); halt_i = hval(); branch_taken_i = rbit();
            e = '0; e.addr_src = ADDR_ALU;
            if (kind == K_LD) e.mem_rd = 1'b1;
            else              e.mem_wr = 1'b1;
            if (i == wm && kind == K_ST) e.retire = 1'b1;
            step({tag, "_mem"}, e, 0);
         end
         if (kind == K_ST) return;
      end
      halt_i = hval(); mem_ready_i = rbit(); branch_taken_i = rbit();
      e = '0; e.rf_wr = 1'b1; e.retire = 1'b1;
      e.wd = (kind == K_LD) ? WD_MEM : WD_ALU;
      step({tag, "_wb"}, e, 0);
   endtask

   task automatic gen(input int kind, output logic [31:0] ir, output logic [3:0] opx);
      logic [31:0] r;
      logic [2:0]  f3;
      logic        alt;
      logic [6:0]  f7;
      int          p;
      r = $urandom; opx = ALU_ADD; ir = r;
      case (kind)
         K_OP: begin
            f3  = 3'($urandom_range(0, 7));
            alt = (f3 == 3'd0 || f3 == 3'd5) ? rbit() : 1'b0;
            ir  = {1'b0, alt, 5'b0, r[24:15], f3, r[11:7], OPC_OP};
            opx = (alt && f3 == 3'd0) ? ALU_SUB : (alt && f3 == 3'd5) ? ALU_SRA : OP_TAB[f3];
         end
         K_OPIMM: begin
            f3  = 3'($urandom_range(0, 7));
            alt = rbit();
            f7  = r[31:25];
            if (f3 == 3'd1) f7 = 7'd0;
            if (f3 == 3'd5) f7 = {1'b0, alt, 5'b0};
            ir  = {f7, r[24:15], f3, r[11:7], OPC_OPIMM};
            opx = (f3 == 3'd5 && alt) ? ALU_SRA : OP_TAB[f3];
         end
         K_LUI:   ir = {r[31:7], OPC_LUI};
         K_AUIPC: ir = {r[31:7], OPC_AUIPC};
         K_JAL:   ir = {r[31:7], OPC_JAL};
         K_JALR:  ir = {r[31:15], 3'd0, r[11:7], OPC_JALR};
         K_BR: begin
            p  = $urandom_range(0, 5);
            f3 = (p < 2) ? 3'(p) : 3'(p + 2);
            ir = {r[31:15], f3, r[11:7], OPC_BRANCH};
         end
         K_LD: begin
            p  = $urandom_range(0, 4);
            f3 = (p < 3) ? 3'(p) : 3'(p + 1);
            ir = {r[31:15], f3, r[11:7], OPC_LOAD};
         end
         K_ST: begin
            f3 = 3'($urandom_range(0, 2));
            ir = {r[31:15], f3, r[11:7], OPC_STORE};
         end
         K_BAD: begin
            p = $urandom_range(0, 3);
            case (p)
               0: ir = {r[31:7], 7'h7F};
               1: ir = {r[31:15], 2'b01, r[12], r[11:7], OPC_BRANCH};
               2: begin
                  p  = $urandom_range(0, 2);
                  f3 = (p == 0) ? 3'd3 : 3'(p + 5);
                  ir = {r[31:15], f3, r[11:7], OPC_LOAD};
               end
               default: begin
                  f3 = 3'($urandom_range(3, 7));
                  ir = {r[31:15], f3, r[11:7], OPC_STORE};
               end
            endcase
         end
         default: ir = INSN_EBREAK;
      endcase
   endtask

   initial begin
      logic [31:0] ir;
      logic [3:0]  opx;
      int          k;
      reset_i = 1'b1; ir_i = '0; mem_ready_i = 1'b0; branch_taken_i = 1'b0; halt_i = 1'b0;
      do_reset();

      run_instr("addi",   32'h0050_0093, K_OPIMM, ALU_ADD, 0, 0, 1'b0, 1'b0);
      run_instr("lw",     32'h0000_A103, K_LD,    ALU_ADD, 0, 3, 1'b0, 1'b0);
      run_instr("beq_t",  32'h0020_8463, K_BR,    ALU_ADD, 0, 0, 1'b1, 1'b0);
      run_instr("beq_nt", 32'h0020_8463, K_BR,    ALU_ADD, 0, 0, 1'b0, 1'b0);
      run_instr("sw_rst", 32'h0020_A023, K_ST,    ALU_ADD, 1, 2, 1'b0, 1'b1);

      // random legal traffic; enough retirements to wrap the 4-bit counter
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(K_OP, K_ST);
         gen(k, ir, opx);
         run_instr("rnd", ir, k, opx, $urandom_range(0, 2), $urandom_range(0, 3),
                   rbit(), 1'b0);
      end

      force_halt = 1'b1;
      run_instr("lw_halt", 32'h0000_A103, K_LD, ALU_ADD, 1, 1, 1'b0, 1'b0);
      force_halt = 1'b0;
      do_halt_fetch();

      do_reset();
      run_instr("op7f", 32'h0000_007F, K_BAD, ALU_ADD, 0, 0, 1'b0, 1'b0);
      do_reset();
      run_instr("ebreak", INSN_EBREAK, K_EBRK, ALU_ADD, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         do_reset();
         k = $urandom_range(K_OP, K_ST);
         gen(k, ir, opx);
         run_instr("pre", ir, k, opx, 0, $urandom_range(0, 1), rbit(), 1'b0);
         gen(K_BAD, ir, opx);
         run_instr("bad", ir, K_BAD, opx, $urandom_range(0, 1), 0, 1'b0, 1'b0);
      end

      do_reset();
      for (int n = 0; n < 10; n++) begin
         k = $urandom_range(K_OP, K_ST);
         gen(k, ir, opx);
         run_instr("tail", ir, k, opx, $urandom_range(0, 1), $urandom_range(0, 2),
                   rbit(), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
